// File: rtl/m68k_bus_pkg.sv
// Shared types for the 68000 chip-select window decoder: FSM states, window table entry, PCB ids.
// Entry fields are sized to the largest supported bus so one struct serves every instance.
package m68k_bus_pkg;

  localparam int MAX_ADDR_W = 32;
  localparam int MAX_WAIT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_WAIT,
    ST_ACK,
    ST_BERR_WAIT,
    ST_BERR
  } bus_state_t;

  typedef struct packed {
    logic                  en;
    logic [MAX_ADDR_W-1:0] base;
    logic [4:0]            width;
    logic [MAX_WAIT_W-1:0] wait_cnt;
  } win_entry_t;

  typedef enum logic [2:0] {
    PCB_ZERO_WING,
    PCB_OUT_ZONE_CONV,
    PCB_OUT_ZONE,
    PCB_HELLFIRE,
    PCB_TRUXTON,
    PCB_FIRESHARK,
    PCB_VIMANA
  } pcb_id_t;

  // Mask of address bits that take part in the compare; width >= addr_w ignores all of them.
  function automatic logic [MAX_ADDR_W-1:0] keep_mask(input logic [4:0] width, input int addr_w);
    logic [MAX_ADDR_W-1:0] m;
    m = '1;
    if (int'(width) >= addr_w) m = '0;
    else m = m << width;
    return m;
  endfunction

endpackage

// File: rtl/window_match.sv
// Combinational priority matcher over the window table; the lowest matching index wins.
module window_match
  import m68k_bus_pkg::*;
#(
  parameter int NUM_WIN = 24,
  parameter int ADDR_W  = 24,
  parameter int IDX_W   = 5
) (
  input  logic [NUM_WIN*$bits(win_entry_t)-1:0] tbl,
  input  logic [ADDR_W-1:0]                     addr,
  output logic [IDX_W-1:0]                      win_idx,
  output logic                                  hit,
  output logic                                  multi_hit
);

  localparam int ENT_W = $bits(win_entry_t);

  logic [MAX_ADDR_W-1:0] a_ext;
  win_entry_t            ent;

  assign a_ext = MAX_ADDR_W'(addr);

  // Walk from the top down so the lowest matching index is the last one written.
  always_comb begin
    hit       = 1'b0;
    multi_hit = 1'b0;
    win_idx   = '0;
    ent       = '0;
    for (int i = NUM_WIN - 1; i >= 0; i--) begin
      ent = win_entry_t'(tbl[i*ENT_W +: ENT_W]);
      if (ent.en && (((a_ext ^ ent.base) & keep_mask(ent.width, ADDR_W)) == '0)) begin
        if (hit) multi_hit = 1'b1;
        hit     = 1'b1;
        win_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/m68k_window_decoder.sv
// Table-driven 68000 chip-select decoder: window table, bus-cycle FSM, wait and timeout counters.
// state      | meaning
// IDLE       | waiting for address strobe
// DECODE     | snapshot match, load wait or timeout counter
// WAIT       | counting wait states before DTACK
// ACK        | dtack_n asserted until strobe released
// BERR_WAIT  | unmapped access, counting down to bus error
// BERR       | berr_n asserted until strobe released
module m68k_window_decoder
  import m68k_bus_pkg::*;
#(
  parameter int NUM_WIN = 24,
  parameter int ADDR_W  = 24,
  parameter int WAIT_W  = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       cfg_we,
  input  logic [$clog2(NUM_WIN)-1:0] cfg_idx,
  input  logic                       cfg_en,
  input  logic [ADDR_W-1:0]          cfg_base,
  input  logic [4:0]                 cfg_width,
  input  logic [WAIT_W-1:0]          cfg_wait,
  input  logic [ADDR_W-1:0]          cpu_a,
  input  logic                       cpu_as_n,
  output logic [NUM_WIN-1:0]         cs,
  output logic                       dtack_n,
  output logic                       berr_n,
  output logic                       multi_hit,
  output logic                       busy
);

  localparam int IDX_W = $clog2(NUM_WIN);
  localparam int ENT_W = $bits(win_entry_t);
  localparam logic [7:0] TCNT_INIT = 8'(TIMEOUT - 1);

  win_entry_t               tbl_q [NUM_WIN];
  win_entry_t               new_ent;
  logic [NUM_WIN*ENT_W-1:0] tbl_flat;
  logic [IDX_W-1:0]         win_idx;
  logic                     m_hit;
  logic                     m_multi;
  logic [MAX_WAIT_W-1:0]    win_wait;
  logic [MAX_WAIT_W-1:0]    wcnt;
  logic [7:0]               tcnt;
  bus_state_t               state;

  assign new_ent = '{en: cfg_en, base: MAX_ADDR_W'(cfg_base), width: cfg_width,
                     wait_cnt: MAX_WAIT_W'(cfg_wait)};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_WIN; i++) tbl_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_WIN; i++)
        if (cfg_we && cfg_idx == IDX_W'(i)) tbl_q[i] <= new_ent;
    end
  end

  for (genvar g = 0; g < NUM_WIN; g++) begin : g_flat
    assign tbl_flat[g*ENT_W +: ENT_W] = tbl_q[g];
  end

  window_match #(
    .NUM_WIN (NUM_WIN),
    .ADDR_W  (ADDR_W),
    .IDX_W   (IDX_W)
  ) u_match (
    .tbl       (tbl_flat),
    .addr      (cpu_a),
    .win_idx   (win_idx),
    .hit       (m_hit),
    .multi_hit (m_multi)
  );

  always_comb begin
    win_wait = '0;
    for (int i = 0; i < NUM_WIN; i++)
      if (win_idx == IDX_W'(i)) win_wait = tbl_q[i].wait_cnt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cs        <= '0;
      dtack_n   <= 1'b1;
      berr_n    <= 1'b1;
      multi_hit <= 1'b0;
      busy      <= 1'b0;
      wcnt      <= '0;
      tcnt      <= '0;
    end else begin
      multi_hit <= 1'b0;
      // Strobe release ends any bus cycle, including mid-wait and mid-timeout aborts.
      if (state != ST_IDLE && cpu_as_n) begin
        state   <= ST_IDLE;
        cs      <= '0;
        dtack_n <= 1'b1;
        berr_n  <= 1'b1;
        busy    <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (!cpu_as_n) begin
              state <= ST_DECODE;
              busy  <= 1'b1;
            end
          end
          ST_DECODE: begin
            multi_hit <= m_multi;
            if (m_hit) begin
              cs   <= {{(NUM_WIN-1){1'b0}}, 1'b1} << win_idx;
              wcnt <= win_wait;
              if (win_wait != '0) begin
                state <= ST_WAIT;
              end else begin
                state   <= ST_ACK;
                dtack_n <= 1'b0;
              end
            end else begin
              tcnt  <= TCNT_INIT;
              state <= ST_BERR_WAIT;
            end
          end
          ST_WAIT: begin
            if (wcnt <= MAX_WAIT_W'(1)) begin
              state   <= ST_ACK;
              dtack_n <= 1'b0;
            end else begin
              wcnt <= wcnt - 1'b1;
            end
          end
          ST_BERR_WAIT: begin
            if (tcnt == '0) begin
              state  <= ST_BERR;
              berr_n <= 1'b0;
            end else begin
              tcnt <= tcnt - 1'b1;
            end
          end
          ST_ACK, ST_BERR: ;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_m68k_window_decoder.sv
// Directed bench for m68k_window_decoder; expected outcomes queued per access and checked as they arrive.
module tb_m68k_window_decoder;

  localparam int NUM_WIN = 24;
  localparam int ADDR_W  = 24;
  localparam int WAIT_W  = 4;
  localparam int TIMEOUT = 64;

  localparam int K_DTACK = 0;
  localparam int K_BERR  = 1;
  localparam int K_ABORT = 2;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 cfg_we;
  logic [4:0]           cfg_idx;
  logic                 cfg_en;
  logic [ADDR_W-1:0]    cfg_base;
  logic [4:0]           cfg_width;
  logic [WAIT_W-1:0]    cfg_wait;
  logic [ADDR_W-1:0]    cpu_a;
  logic                 cpu_as_n;
  logic [NUM_WIN-1:0]   cs;
  logic                 dtack_n;
  logic                 berr_n;
  logic                 multi_hit;
  logic                 busy;

  typedef struct {
    logic [NUM_WIN-1:0] cs;
    int                 kind;
    int                 lat;
    logic               multi;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  m68k_window_decoder #(
    .NUM_WIN (NUM_WIN),
    .ADDR_W  (ADDR_W),
    .WAIT_W  (WAIT_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cfg_we    (cfg_we),
    .cfg_idx   (cfg_idx),
    .cfg_en    (cfg_en),
    .cfg_base  (cfg_base),
    .cfg_width (cfg_width),
    .cfg_wait  (cfg_wait),
    .cpu_a     (cpu_a),
    .cpu_as_n  (cpu_as_n),
    .cs        (cs),
    .dtack_n   (dtack_n),
    .berr_n    (berr_n),
    .multi_hit (multi_hit),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input int idx, input int kind, input int lat, input logic multi);
    exp_t e;
    e.cs    = (idx < 0) ? '0 : (NUM_WIN'(1) << idx);
    e.kind  = kind;
    e.lat   = lat;
    e.multi = multi;
    return e;
  endfunction

  task automatic cfg_write(input int idx, input logic en, input logic [ADDR_W-1:0] base,
                           input int width, input int wt);
    @(negedge clk);
    cfg_idx   = 5'(idx);
    cfg_en    = en;
    cfg_base  = base;
    cfg_width = 5'(width);
    cfg_wait  = WAIT_W'(wt);
    cfg_we    = 1'b1;
    @(negedge clk);
    cfg_we    = 1'b0;
  endtask

  // One bus cycle: latency counted in rising edges from the first strobe-low sample.
  task automatic access(input string tag, input logic [ADDR_W-1:0] addr, input exp_t e,
                        input int abort_n, input int wr_n, input bit hold);
    exp_t x;
    int   n;
    bit   done;
    sb.push_back(e);
    x = mk(-1, K_DTACK, 0, 1'b0);
    @(negedge clk);
    cpu_a    = addr;
    cpu_as_n = 1'b0;
    n    = 0;
    done = 0;
    while (!done && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) check({tag, " busy@1"}, busy, 1);
      if (n == 2) begin
        x = sb.pop_front();
        check({tag, " cs@2"}, cs, x.cs);
        check({tag, " multi_hit@2"}, multi_hit, x.multi);
        cpu_a = ~addr;
      end
      if (wr_n != 0 && n == wr_n) begin
        cfg_idx = 5'd0; cfg_en = 1'b0; cfg_base = '0; cfg_width = 5'd19; cfg_wait = 4'd4;
        cfg_we  = 1'b1;
      end
      if (wr_n != 0 && n == wr_n + 1) cfg_we = 1'b0;
      if (!dtack_n || !berr_n) done = 1;
      if (abort_n != 0 && n == abort_n - 1) cpu_as_n = 1'b1;
      if (abort_n != 0 && n == abort_n) done = 1;
    end
    check({tag, " latency"}, n, x.lat);
    check({tag, " dtack_n"}, dtack_n, (x.kind == K_DTACK) ? 0 : 1);
    check({tag, " berr_n"}, berr_n, (x.kind == K_BERR) ? 0 : 1);
    if (x.kind == K_ABORT) begin
      check({tag, " abort cs"}, cs, 0);
      check({tag, " abort busy"}, busy, 0);
    end else if (!hold) begin
      @(negedge clk);
      cpu_as_n = 1'b1;
      @(posedge clk);
      #1;
      check({tag, " rel cs"}, cs, 0);
      check({tag, " rel dtack_n"}, dtack_n, 1);
      check({tag, " rel berr_n"}, berr_n, 1);
      check({tag, " rel busy"}, busy, 0);
      check({tag, " rel multi_hit"}, multi_hit, 0);
    end
  endtask

  initial begin
    reset_n = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_en = 1'b0; cfg_base = '0;
    cfg_width = '0; cfg_wait = '0; cpu_a = '0; cpu_as_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset cs", cs, 0);
    check("reset dtack_n", dtack_n, 1);
    check("reset berr_n", berr_n, 1);
    check("reset multi_hit", multi_hit, 0);
    check("reset busy", busy, 0);
    @(negedge clk);
    reset_n = 1'b1;

    cfg_write(0, 1'b1, 24'h000000, 19, 0);
    access("win0", 24'h07FFFE, mk(0, K_DTACK, 2, 1'b0), 0, 0, 0);

    cfg_write(5, 1'b1, 24'h440000, 12, 3);
    access("win5", 24'h440FFE, mk(5, K_DTACK, 5, 1'b0), 0, 0, 0);
    access("miss", 24'h441000, mk(-1, K_BERR, 2 + TIMEOUT, 1'b0), 0, 0, 0);

    cfg_write(2, 1'b1, 24'h400000, 11, 0);
    cfg_write(3, 1'b1, 24'h400000, 1, 0);
    access("overlap", 24'h400000, mk(2, K_DTACK, 2, 1'b1), 0, 0, 0);

    cfg_write(7, 1'b1, 24'h500000, 8, 15);
    access("abort", 24'h5000AA, mk(7, K_ABORT, 6, 1'b0), 6, 0, 0);
    access("abort_berr", 24'h700000, mk(-1, K_ABORT, 10, 1'b0), 10, 0, 0);

    cfg_write(0, 1'b1, 24'h000000, 19, 4);
    access("wr_in_wait", 24'h000000, mk(0, K_DTACK, 6, 1'b0), 0, 3, 0);
    access("after_dis", 24'h000000, mk(-1, K_BERR, 2 + TIMEOUT, 1'b0), 0, 0, 0);

    cfg_write(1, 1'b1, 24'h600000, 8, 0);
    access("pre_reset", 24'h600010, mk(1, K_DTACK, 2, 1'b0), 0, 0, 1);
    @(negedge clk);
    #2;
    reset_n  = 1'b0;
    cpu_as_n = 1'b1;
    #1;
    check("async rst cs", cs, 0);
    check("async rst dtack_n", dtack_n, 1);
    check("async rst busy", busy, 0);
    @(negedge clk);
    reset_n = 1'b1;
    access("cleared", 24'h600010, mk(-1, K_BERR, 2 + TIMEOUT, 1'b0), 0, 0, 0);

    cfg_write(20, 1'b1, 24'hABCDEF, 24, 1);
    access("full_width", 24'h123456, mk(20, K_DTACK, 3, 1'b0), 0, 0, 0);

    check("scoreboard empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
